// File: rtl/rom_arb_pkg.sv
// ---------------------------------------------------------------------------
// rom_arb_pkg
// Shared types and constants for the ROM read arbiter.
//   arb_state_t : arbiter FSM states
//   ROM_WORD_AW : default ROM word-address width (16 KB window)
//   ROM_BYTES   : default ROM window size in bytes
//   ERR_DATA    : read data returned for out-of-window requests
// ---------------------------------------------------------------------------
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } arb_state_t;

    localparam int          ROM_WORD_AW = 12;
    localparam int          ROM_BYTES   = 4 << ROM_WORD_AW;
    localparam logic [31:0] ERR_DATA    = 32'h0;

endpackage

// File: rtl/rom_read_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request at or above
// ptr wins, otherwise the search wraps around to index 0.
// Ports:
//   req  in  N          request vector
//   ptr  in  clog2(N)   highest-priority index this cycle
//   gnt  out N          one-hot grant (zero when no request)
//   idx  out clog2(N)   encoded winner index
//   any  out 1          at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IDX_W = $clog2(N);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Pass 1: indices at or above the pointer.
        for (int i = 0; i < N; i++) begin
            if (!any && req[i] && (IDX_W'(i) >= ptr)) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
        // Pass 2: wrap to the indices below the pointer.
        for (int i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// ---------------------------------------------------------------------------
// rom_read_arbiter
// Shares one ROM macro between NUM_REQ read requesters. Round-robin grant,
// ROM CS/OE/A sequencing and a response hold buffer for backpressure.
//
// State table:
//   IDLE | arbitrate; on grant drive req_ready and ROM CS/address
//   READ | ROM data (or error) presented to the winner, data buffered
//   HOLD | winner has not accepted yet; serve buffered data
//
// Ports:
//   clk, rst (sync, active-low)
//   req_valid/req_ready/req_addr/req_id     per-requester request channel
//   rsp_valid/rsp_ready, rsp_data/id/err    response channel (shared bus)
//   ROM_enable/ROM_read/ROM_address/ROM_out ROM macro interface
//
// Optional: define ROM_ARB_LASTHIT_EN to add a last-word register that
// serves repeated reads of the same word without touching the ROM.
// ---------------------------------------------------------------------------
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int          NUM_REQ  = 2,
    parameter int          ID_W     = 8,
    parameter logic [31:0] ROM_BASE = 32'h0000_0000,
    parameter int          ROM_AW   = ROM_WORD_AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_addr,
    input  logic [NUM_REQ*ID_W-1:0] req_id,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [31:0]             rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_err,
    output logic                    ROM_enable,
    output logic                    ROM_read,
    output logic [ROM_AW-1:0]       ROM_address,
    input  logic [31:0]             ROM_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // Window end in 33 bits so a window touching 4 GB does not wrap.
    localparam logic [32:0] WIN_END = {1'b0, ROM_BASE} + (33'd4 << ROM_AW);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, win_q, arb_idx, ptr_next;
    logic [NUM_REQ-1:0]   arb_gnt, win_onehot;
    logic                 arb_any;
    logic [ID_W-1:0]      id_q;
    logic                 err_q;
    logic [31:0]          buf_q;
    logic [31:0]          cand_addr;
    logic [ID_W-1:0]      cand_id;
    logic                 cand_in_range;
    logic [ROM_AW-1:0]    cand_word;
    logic                 lh_hit, grant_hit;
    logic [31:0]          lh_data;
    logic [31:0]          read_data;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        cand_addr = '0;
        cand_id   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == arb_idx) begin
                cand_addr = req_addr[32*i +: 32];
                cand_id   = req_id[ID_W*i +: ID_W];
            end
        end
    end

    assign cand_in_range = ({1'b0, cand_addr} >= {1'b0, ROM_BASE}) &&
                           ({1'b0, cand_addr} < WIN_END);
    // Byte offset to word address; the low two bits are simply dropped.
    assign cand_word  = ROM_AW'((cand_addr - ROM_BASE) >> 2);
    assign ptr_next   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
    assign win_onehot = NUM_REQ'(1) << win_q;
    assign read_data  = err_q ? ERR_DATA : ROM_out;
    assign grant_hit  = cand_in_range && lh_hit;

`ifdef ROM_ARB_LASTHIT_EN
    logic              lh_valid_q;
    logic [ROM_AW-1:0] lh_word_q;
    logic [ROM_AW-1:0] word_q;
    logic [31:0]       lh_data_q;

    assign lh_hit  = lh_valid_q && (lh_word_q == cand_word);
    assign lh_data = lh_data_q;

    // ROM contents never change, so the entry is only invalidated by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lh_valid_q <= 1'b0;
            lh_word_q  <= '0;
            lh_data_q  <= '0;
            word_q     <= '0;
        end else begin
            if (state_q == IDLE && arb_any)
                word_q <= cand_word;
            if (state_q == READ && !err_q) begin
                lh_valid_q <= 1'b1;
                lh_word_q  <= word_q;
                lh_data_q  <= ROM_out;
            end
        end
    end
`else
    assign lh_hit  = 1'b0;
    assign lh_data = '0;
`endif

    always_comb begin
        state_d     = state_q;
        req_ready   = '0;
        rsp_valid   = '0;
        rsp_data    = '0;
        rsp_id      = '0;
        rsp_err     = 1'b0;
        ROM_enable  = 1'b0;
        ROM_read    = 1'b0;
        ROM_address = '0;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready = arb_gnt;
                    if (cand_in_range && !grant_hit) begin
                        ROM_enable  = 1'b1;
                        ROM_address = cand_word;
                    end
                    // A last-word hit skips the ROM cycle and serves from HOLD.
                    state_d = grant_hit ? HOLD : READ;
                end
            end
            READ: begin
                ROM_read  = !err_q;
                rsp_valid = win_onehot;
                rsp_id    = id_q;
                rsp_err   = err_q;
                rsp_data  = read_data;
                state_d   = rsp_ready[win_q] ? IDLE : HOLD;
            end
            HOLD: begin
                rsp_valid = win_onehot;
                rsp_id    = id_q;
                rsp_err   = err_q;
                rsp_data  = buf_q;
                if (rsp_ready[win_q])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && arb_any) begin
                ptr_q <= ptr_next;
                win_q <= arb_idx;
                id_q  <= cand_id;
                err_q <= !cand_in_range;
                if (grant_hit)
                    buf_q <= lh_data;
            end
            // Buffer what was presented so HOLD repeats it exactly.
            if (state_q == READ)
                buf_q <= read_data;
        end
    end

endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
- Shares the single 16 KB instruction/boot ROM macro between NUM_REQ read requesters, e.g. the IF-stage AXI slave port and the DMA/boot-copy engine.
- Each requester uses a simple valid/ready request channel and a valid/ready response channel.
- The block round-robin arbitrates between requesters, sequences the ROM CS/OE/A protocol, and buffers the read data until the winner accepts it.
- It sits between the requester-side wrappers and the ROM macro ports.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 8, width of the transaction tag returned with each response.
- ROM_BASE, 32'h0000_0000, byte base address of the ROM window.
- ROM_AW, 12, ROM word-address width (window size = 4 << ROM_AW bytes).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accepted (one-hot or zero).
- req_addr  in  NUM_REQ*32  byte addresses, requester i at [32*i +: 32].
- req_id  in  NUM_REQ*ID_W  request tags.
- rsp_valid  out  NUM_REQ  response valid, one-hot to the granted requester.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_data  out  32  read data (shared bus, qualified by rsp_valid).
- rsp_id  out  ID_W  tag of the granted request.
- rsp_err  out  1  1 = address outside the ROM window.
- ROM_enable  out  1  ROM CS.
- ROM_read  out  1  ROM OE.
- ROM_address  out  ROM_AW  ROM word address.
- ROM_out  in  32  ROM DO, valid in the cycle after CS.

Behaviour:
- Reset (rst=0 at a clk edge, in any state, including mid-transaction):
  - next state IDLE; RR pointer = 0; grant, id, err and buffer registers cleared.
  - every output is 0, combinationally in IDLE.
  - an in-flight response is dropped; requesters must also be reset.
- States: IDLE, READ, HOLD.
- IDLE:
  - Winner selection: the first requester i with req_valid[i]=1, searching upward from the RR pointer with wrap.
  - Grant cycle outputs: req_ready[winner]=1. If the address is in range, also ROM_enable=1 and ROM_address=(req_addr-ROM_BASE)[ROM_AW+1:2].
  - Latched at the grant edge: winner index, req_id, and err = (addr < ROM_BASE or addr >= ROM_BASE+(4<<ROM_AW)).
  - On grant: RR pointer becomes (winner+1) mod NUM_REQ; go to READ.
  - No req_valid: stay in IDLE with all outputs 0.
- READ:
  - Outputs: ROM_read=1 (0 if err); rsp_valid[winner]=1; rsp_id=latched id; rsp_err=err; rsp_data=ROM_out (32'h0 if err).
  - ROM_out is registered into a hold buffer every READ cycle.
  - rsp_ready[winner]=1: go to IDLE. Otherwise go to HOLD.
- HOLD:
  - rsp_valid[winner]=1; rsp_data=buffer; ROM_enable=ROM_read=0.
  - Go to IDLE on rsp_ready[winner].
- Latency and throughput: data is presented 1 cycle after the grant; at most one request every 2 cycles.
- req_ready is never asserted outside IDLE, and never for more than one requester.
- Simultaneous requests from all requesters are served in RR order; there is no starvation.
- Unaligned address: bits [1:0] are ignored (word read); no error is raised.
- rsp_valid must not drop before handshake; rsp_data and rsp_id must be stable while in HOLD.
- Address arithmetic is 32-bit unsigned; the window end is computed in 33 bits so it does not wrap.
- ROM_address is 0 whenever ROM_enable=0.

Optional Feature:
- Macro ROM_ARB_LASTHIT_EN: adds a last-word register (valid bit, ROM word address, data).
  - Set on every READ completion; cleared only by reset, since the ROM is read-only.
  - On an in-range grant whose word address equals the stored address with the valid bit set: ROM_enable stays 0, next state is HOLD, and the response is served from the register with the same 1-cycle latency.
- Without the macro: every in-range grant accesses the ROM and the timing is exactly as above.

Decomposition:
- Package rom_arb_pkg contains:
  - state enum arb_state_t {IDLE, READ, HOLD};
  - ROM_BYTES and ROM_WORD_AW constants;
  - an err data constant 32'h0.
- One sub-module, rr_arbiter, is natural: parameter N, inputs req[N] and ptr, output one-hot gnt[N] plus an encoded index.

Test Plan:
- Single access: req_valid=01, req_addr[0]=0x0000_0010, ROM word 4=0xDEAD_BEEF, rsp_ready=1 → at the grant edge ROM_enable=1 and ROM_address=4; 1 cycle later rsp_valid=01, rsp_data=0xDEAD_BEEF, rsp_err=0.
- Round robin: both requesters hold valid for 6 cycles, always ready → grants alternate 0,1,0 and each rsp_id matches its requester's tag.
- Backpressure: rsp_ready[1]=0 for 3 cycles after READ → state HOLD, rsp_data held at the READ-cycle value, ROM_enable=0, no new req_ready.
- Out of range: addr 0x0000_4000 with ROM_AW=12 → no CS, rsp_err=1, rsp_data=0.
- Reset mid-HOLD: rst=0 for one edge → next cycle all outputs 0, and the next grant goes to requester 0.
- With ROM_ARB_LASTHIT_EN: two back-to-back reads of 0x20 → the second has ROM_enable=0 and identical rsp_data.
